// File: rtl/czono_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : czono_pkg
//  Description : Shared FP32 constants, state encoding and index-width helper
//                for the constrained-zonotope datapath blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package czono_pkg;

  // FP32 encodings used by the arithmetic units and the datapath
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  // Default maximum dimension and the index width it implies
  localparam int NMAX_DEFAULT = 512;
  localparam int IDX_W        = $clog2(NMAX_DEFAULT);

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Index width for a given maximum dimension (at least one bit)
  function automatic int idx_width(input int nmax);
    return (nmax > 1) ? $clog2(nmax) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/czono_if.sv
`default_nettype none
// ============================================================================
//  Module      : CZonotope
//  Description : Constrained zonotope bundle: centre c, generators G (n x ng),
//                constraints A (nc x ng) and b (nc), plus the live dimensions.
//  Revision    : 1.0  initial release
// ============================================================================
interface CZonotope #(
  parameter int NMAX       = 512,
  parameter int DATA_WIDTH = 32
);
  localparam int IW = (NMAX > 1) ? $clog2(NMAX) : 1;

  logic [IW-1:0]         n;
  logic [IW-1:0]         ng;
  logic [IW-1:0]         nc;
  logic [DATA_WIDTH-1:0] c [NMAX];
  logic [DATA_WIDTH-1:0] G [NMAX][NMAX];
  logic [DATA_WIDTH-1:0] A [NMAX][NMAX];
  logic [DATA_WIDTH-1:0] b [NMAX];

  modport rd (input  n, ng, nc, c, G, A, b);
  modport wr (output n, ng, nc, c, G, A, b);
endinterface
`default_nettype wire

// File: rtl/Add_Sub.sv
`default_nettype none
// ============================================================================
//  Module      : Add_Sub
//  Description : Combinational IEEE-754 single-precision adder/subtractor,
//                round-to-nearest-even, subnormals flushed to signed zero.
//                AddBar_Sub = 0 adds, 1 subtracts.
//  Revision    : 1.0  initial release
// ============================================================================
module Add_Sub
  import czono_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        AddBar_Sub,
  output logic [31:0] o_result
);

  logic [31:0]       w_b, w_big, w_small;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [7:0]        w_diff_exp;
  logic [26:0]       w_m_big, w_m_small, w_m_shift, w_mask, w_norm;
  logic [27:0]       w_sum;
  logic [4:0]        w_lz;
  logic              w_found, w_sticky, w_round_up, w_cancel;
  logic signed [9:0] w_exp;
  logic [24:0]       w_rnd;
  logic              w_unused;

  assign w_b        = {i_b[31] ^ AddBar_Sub, i_b[30:0]};
  assign w_a_nan    = (&i_a[30:23]) & (|i_a[22:0]);
  assign w_b_nan    = (&w_b[30:23]) & (|w_b[22:0]);
  assign w_a_inf    = (&i_a[30:23]) & ~(|i_a[22:0]);
  assign w_b_inf    = (&w_b[30:23]) & ~(|w_b[22:0]);
  assign w_a_zero   = ~(|i_a[30:23]);
  assign w_b_zero   = ~(|w_b[30:23]);
  assign w_big      = (i_a[30:0] >= w_b[30:0]) ? i_a : w_b;
  assign w_small    = (i_a[30:0] >= w_b[30:0]) ? w_b : i_a;
  assign w_diff_exp = w_big[30:23] - w_small[30:23];
  // Significands carry three extra bits: guard, round, sticky
  assign w_m_big    = {1'b1, w_big[22:0], 3'b000};
  assign w_m_small  = {1'b1, w_small[22:0], 3'b000};
  assign w_unused   = ^{w_rnd[23], w_found};

  // Align the smaller operand, add or subtract magnitudes, normalise, round
  always_comb begin
    w_mask     = '0;
    w_sticky   = 1'b0;
    w_m_shift  = 27'd1;
    w_sum      = '0;
    w_norm     = '0;
    w_lz       = '0;
    w_found    = 1'b0;
    w_cancel   = 1'b0;
    w_exp      = $signed({2'b00, w_big[30:23]});
    if (w_diff_exp <= 8'd26) begin
      w_mask    = (27'd1 << w_diff_exp) - 27'd1;
      w_sticky  = |(w_m_small & w_mask);
      w_m_shift = (w_m_small >> w_diff_exp) | {26'd0, w_sticky};
    end
    if (w_big[31] == w_small[31]) begin
      w_sum = {1'b0, w_m_big} + {1'b0, w_m_shift};
      if (w_sum[27]) begin
        w_norm = w_sum[27:1] | {26'd0, w_sum[0]};
        w_exp  = w_exp + 10'sd1;
      end else begin
        w_norm = w_sum[26:0];
      end
    end else begin
      w_norm   = w_m_big - w_m_shift;
      w_cancel = (w_norm == '0);
      for (int p = 26; p >= 0; p--) begin
        if (!w_found && w_norm[p]) begin
          w_found = 1'b1;
          w_lz    = 5'(26 - p);
        end
      end
      w_norm = w_norm << w_lz;
      w_exp  = w_exp - $signed({5'd0, w_lz});
    end
    w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rnd      = {1'b0, w_norm[26:3]} + {24'd0, w_round_up};
    if (w_rnd[24]) begin
      w_rnd = w_rnd >> 1;
      w_exp = w_exp + 10'sd1;
    end
  end

  // Special operands first, then exact cancellation, overflow/underflow
  always_comb begin
    o_result = FP_ZERO;
    if (w_a_nan || w_b_nan)
      o_result = FP_QNAN;
    else if (w_a_inf && w_b_inf)
      o_result = (i_a[31] == w_b[31]) ? i_a : FP_QNAN;
    else if (w_a_inf)
      o_result = i_a;
    else if (w_b_inf)
      o_result = w_b;
    else if (w_a_zero && w_b_zero)
      o_result = {i_a[31] & w_b[31], 31'd0};
    else if (w_a_zero)
      o_result = w_b;
    else if (w_b_zero)
      o_result = i_a;
    else if (w_cancel)
      o_result = FP_ZERO;
    else if (w_exp >= 10'sd255)
      o_result = {w_big[31], 8'hFF, 23'd0};
    else if (w_exp <= 10'sd0)
      o_result = {w_big[31], 31'd0};
    else
      o_result = {w_big[31], w_exp[7:0], w_rnd[22:0]};
  end

endmodule
`default_nettype wire

// File: rtl/fp_mul.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mul
//  Description : Combinational IEEE-754 single-precision multiplier,
//                round-to-nearest-even, subnormals flushed to signed zero.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_mul
  import czono_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result
);

  logic               w_sign;
  logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [47:0]        w_prod;
  logic [23:0]        w_mant;
  logic               w_guard, w_sticky, w_round_up;
  logic [24:0]        w_rnd;
  logic signed [10:0] w_exp;
  logic               w_unused;

  assign w_sign   = i_a[31] ^ i_b[31];
  assign w_a_nan  = (&i_a[30:23]) & (|i_a[22:0]);
  assign w_b_nan  = (&i_b[30:23]) & (|i_b[22:0]);
  assign w_a_inf  = (&i_a[30:23]) & ~(|i_a[22:0]);
  assign w_b_inf  = (&i_b[30:23]) & ~(|i_b[22:0]);
  assign w_a_zero = ~(|i_a[30:23]);
  assign w_b_zero = ~(|i_b[30:23]);
  assign w_prod   = {24'd0, 1'b1, i_a[22:0]} * {24'd0, 1'b1, i_b[22:0]};
  assign w_unused = w_rnd[23];

  // Normalise the 48-bit significand product and round to 24 bits
  always_comb begin
    w_exp      = $signed({3'b000, i_a[30:23]}) + $signed({3'b000, i_b[30:23]}) - 11'sd127;
    w_mant     = w_prod[46:23];
    w_guard    = w_prod[22];
    w_sticky   = |w_prod[21:0];
    if (w_prod[47]) begin
      w_mant   = w_prod[47:24];
      w_guard  = w_prod[23];
      w_sticky = |w_prod[22:0];
      w_exp    = w_exp + 11'sd1;
    end
    w_round_up = w_guard & (w_sticky | w_mant[0]);
    w_rnd      = {1'b0, w_mant} + {24'd0, w_round_up};
    if (w_rnd[24]) begin
      w_rnd = w_rnd >> 1;
      w_exp = w_exp + 11'sd1;
    end
  end

  // Special operands first, then overflow/underflow, then the normal result
  always_comb begin
    o_result = FP_ZERO;
    if (w_a_nan || w_b_nan)
      o_result = FP_QNAN;
    else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      o_result = FP_QNAN;
    else if (w_a_inf || w_b_inf)
      o_result = {w_sign, 8'hFF, 23'd0};
    else if (w_a_zero || w_b_zero)
      o_result = {w_sign, 31'd0};
    else if (w_exp >= 11'sd255)
      o_result = {w_sign, 8'hFF, 23'd0};
    else if (w_exp <= 11'sd0)
      o_result = {w_sign, 31'd0};
    else
      o_result = {w_sign, w_exp[7:0], w_rnd[22:0]};
  end

endmodule
`default_nettype wire

// File: rtl/lin_map.sv
`default_nettype none
// ============================================================================
//  Module      : lin_map
//  Description : Linear image of a constrained zonotope, OUT = M*Z, using one
//                FP32 multiplier and one FP32 adder. M is streamed from an
//                external synchronous memory addressed as {row, col}.
//  Revision    : 1.0  initial release
// ============================================================================
module lin_map
  import czono_pkg::*;
#(
  parameter int NMAX       = 512,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [2*$clog2(NMAX)-1:0]   m_addr_o,
  input  logic [DATA_WIDTH-1:0]       m_data_i,
  CZonotope.rd                        Z,
  CZonotope.wr                        OUT
);

  localparam int            IW          = idx_width(NMAX);
  localparam logic [IW-1:0] c_idx_one   = IW'(1);

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_n, r_ng, r_nc;
  logic [IW-1:0]         r_i, r_j, r_k, r_kd;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] w_z_elem, w_prod, w_sum, w_acc_nxt;
  logic                  w_dot_end, w_row_end, w_last;

  assign OUT.n  = r_n;
  assign OUT.ng = r_ng;
  assign OUT.nc = r_nc;

  // Loop-end conditions: k==n closes a dot product, j==ng closes a row
  assign w_dot_end = (r_k == r_n);
  assign w_row_end = (r_j == r_ng);
  assign w_last    = w_dot_end && w_row_end && (r_i == r_n - c_idx_one);

  // Column j=0 is the centre, column j>=1 is generator j-1; k is one cycle late
  assign w_z_elem  = (r_j == '0) ? Z.c[r_kd] : Z.G[r_kd][r_j - c_idx_one];
  // First product seeds the accumulator so a -0 dot product stays -0
  assign w_acc_nxt = (r_k == c_idx_one) ? w_prod : w_sum;

  fp_mul u_mul (
    .i_a      (m_data_i),
    .i_b      (w_z_elem),
    .o_result (w_prod)
  );

  Add_Sub u_add (
    .i_a        (r_acc),
    .i_b        (w_prod),
    .AddBar_Sub (1'b0),
    .o_result   (w_sum)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and control outputs
  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    m_addr_o    = '0;
    case (r_state)
      IDLE: if (start_i) w_state_nxt = LOAD;
      LOAD: begin
        busy_o      = 1'b1;
        w_state_nxt = (Z.n == '0) ? DONE : RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (!w_dot_end) m_addr_o = {r_i, r_k};
        if (w_last)     w_state_nxt = DONE;
      end
      DONE: begin
        done_o      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on LOAD, sweep i/j/k and accumulate during RUN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_n   <= '0;
      r_ng  <= '0;
      r_nc  <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_kd  <= '0;
      r_acc <= '0;
      for (int r = 0; r < NMAX; r++) begin
        OUT.c[r] <= '0;
        OUT.b[r] <= '0;
        for (int q = 0; q < NMAX; q++) begin
          OUT.G[r][q] <= '0;
          OUT.A[r][q] <= '0;
        end
      end
    end else begin
      case (r_state)
        LOAD: begin
          r_n   <= Z.n;
          r_ng  <= Z.ng;
          r_nc  <= Z.nc;
          r_i   <= '0;
          r_j   <= '0;
          r_k   <= '0;
          r_kd  <= '0;
          r_acc <= '0;
          // Anything outside the live n/ng/nc ranges is forced to zero
          for (int r = 0; r < NMAX; r++) begin
            OUT.c[r] <= '0;
            OUT.b[r] <= (r < int'(Z.nc)) ? Z.b[r] : '0;
            for (int q = 0; q < NMAX; q++) begin
              OUT.G[r][q] <= '0;
              OUT.A[r][q] <= (r < int'(Z.nc) && q < int'(Z.ng)) ? Z.A[r][q] : '0;
            end
          end
        end
        RUN: begin
          r_kd <= r_k;
          if (r_k != '0) r_acc <= w_acc_nxt;
          if (w_dot_end) begin
            if (r_j == '0) OUT.c[r_i] <= w_acc_nxt;
            else           OUT.G[r_i][r_j - c_idx_one] <= w_acc_nxt;
            r_k <= '0;
            if (w_row_end) begin
              r_j <= '0;
              r_i <= r_i + c_idx_one;
            end else begin
              r_j <= r_j + c_idx_one;
            end
          end else begin
            r_k <= r_k + c_idx_one;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lin_map.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lin_map
//  Description : Directed self-checking bench for lin_map with a result
//                scoreboard; small NMAX keeps the OUT arrays cheap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lin_map;
  import czono_pkg::*;

  localparam int NM = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [31:0]                 lat;
    logic [IW-1:0]               n, ng, nc;
    logic [NM-1:0][31:0]         c;
    logic [NM-1:0][NM-1:0][31:0] G;
    logic [NM-1:0][NM-1:0][31:0] A;
    logic [NM-1:0][31:0]         b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] M_mem [NM][NM];

  exp_t sb_q[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  CZonotope #(.NMAX(NM), .DATA_WIDTH(32)) z_if ();
  CZonotope #(.NMAX(NM), .DATA_WIDTH(32)) out_if ();

  lin_map #(.NMAX(NM), .DATA_WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .busy_o   (busy),
    .done_o   (done),
    .m_addr_o (m_addr),
    .m_data_i (m_data),
    .Z        (z_if),
    .OUT      (out_if)
  );

  always #5 clk = ~clk;

  // Synchronous M memory, one-cycle read latency
  always_ff @(posedge clk) m_data <= M_mem[m_addr[3:2]][m_addr[1:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic new_case(input int n, input int ng, input int nc, input int lat);
    for (int r = 0; r < NM; r++) begin
      z_if.c[r] = 32'h0;
      z_if.b[r] = 32'h0;
      for (int q = 0; q < NM; q++) begin
        z_if.G[r][q] = 32'h0;
        z_if.A[r][q] = 32'h0;
        M_mem[r][q]  = 32'h0;
      end
    end
    z_if.n  = IW'(n);
    z_if.ng = IW'(ng);
    z_if.nc = IW'(nc);
    cur     = '0;
    cur.n   = IW'(n);
    cur.ng  = IW'(ng);
    cur.nc  = IW'(nc);
    cur.lat = 32'(lat);
  endtask

  task automatic compare_out(input string name, input exp_t e);
    check({name, " n"},  32'(out_if.n),  32'(e.n));
    check({name, " ng"}, 32'(out_if.ng), 32'(e.ng));
    check({name, " nc"}, 32'(out_if.nc), 32'(e.nc));
    for (int r = 0; r < NM; r++) begin
      check($sformatf("%s c[%0d]", name, r), out_if.c[r], e.c[r]);
      check($sformatf("%s b[%0d]", name, r), out_if.b[r], e.b[r]);
      for (int q = 0; q < NM; q++) begin
        check($sformatf("%s G[%0d][%0d]", name, r, q), out_if.G[r][q], e.G[r][q]);
        check($sformatf("%s A[%0d][%0d]", name, r, q), out_if.A[r][q], e.A[r][q]);
      end
    end
  endtask

  // Queue the expectation, pulse start, wait (bounded) for done, then score
  task automatic run_op(input string name);
    int   cnt;
    exp_t e;
    sb_q.push_back(cur);
    @(negedge clk);
    start = 1'b1;
    cnt   = 0;
    while (cnt < 300) begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
      if (done) break;
    end
    e = sb_q.pop_front();
    check({name, " latency"}, 32'(cnt), e.lat);
    compare_out(name, e);
    @(negedge clk);
    check({name, " done width"}, 32'(done), 32'd0);
    check({name, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    int pulses;
    rst   = 1'b1;
    start = 1'b0;
    new_case(0, 0, 0, 2);
    repeat (3) @(negedge clk);
    check("rst busy",   32'(busy),        32'd0);
    check("rst done",   32'(done),        32'd0);
    check("rst addr",   32'(m_addr),      32'd0);
    check("rst n",      32'(out_if.n),    32'd0);
    check("rst c0",     out_if.c[0],      32'd0);
    check("rst G10",    out_if.G[1][0],   32'd0);
    rst = 1'b0;

    // Identity map, nc=0 with junk in Z.A/Z.b that must not reach OUT
    new_case(2, 1, 0, 14);
    M_mem[0][0] = 32'h3F800000; M_mem[1][1] = 32'h3F800000;
    z_if.c[0] = 32'h3F800000; z_if.c[1] = 32'h40000000;
    z_if.G[0][0] = 32'h3F800000; z_if.G[1][0] = 32'h40400000;
    z_if.A[0][0] = 32'h41200000; z_if.b[0] = 32'h41300000;
    cur.c[0] = 32'h3F800000; cur.c[1] = 32'h40000000;
    cur.G[0][0] = 32'h3F800000; cur.G[1][0] = 32'h40400000;
    run_op("ident");

    // diag(2,3)
    new_case(2, 1, 0, 14);
    M_mem[0][0] = 32'h40000000; M_mem[1][1] = 32'h40400000;
    z_if.c[0] = 32'h3F800000; z_if.c[1] = 32'h3F800000;
    z_if.G[0][0] = 32'h3F800000; z_if.G[1][0] = 32'h3F800000;
    cur.c[0] = 32'h40000000; cur.c[1] = 32'h40400000;
    cur.G[0][0] = 32'h40000000; cur.G[1][0] = 32'h40400000;
    run_op("diag");

    // Upper-triangular M with one constraint carried through
    new_case(2, 1, 1, 14);
    M_mem[0][0] = 32'h3F800000; M_mem[0][1] = 32'h3F800000; M_mem[1][1] = 32'h3F800000;
    z_if.c[0] = 32'h3F800000; z_if.c[1] = 32'h40000000;
    z_if.G[0][0] = 32'h3F800000; z_if.G[1][0] = 32'h3F800000;
    z_if.A[0][0] = 32'h40A00000; z_if.b[0] = 32'h41000000;
    cur.c[0] = 32'h40400000; cur.c[1] = 32'h40000000;
    cur.G[0][0] = 32'h40000000; cur.G[1][0] = 32'h3F800000;
    cur.A[0][0] = 32'h40A00000; cur.b[0] = 32'h41000000;
    run_op("tri");

    // ng=0: only c computed; G and A (nc x 0) stay zero, b copied
    new_case(2, 0, 1, 8);
    M_mem[0][0] = 32'h40000000; M_mem[1][1] = 32'h40400000;
    z_if.c[0] = 32'h3F800000; z_if.c[1] = 32'h3F800000;
    z_if.G[0][0] = 32'h40E00000; z_if.A[0][0] = 32'h40C00000; z_if.b[0] = 32'h41000000;
    cur.c[0] = 32'h40000000; cur.c[1] = 32'h40400000;
    cur.b[0] = 32'h41000000;
    run_op("ng0");

    // Negative-zero dot product must stay -0
    new_case(1, 0, 0, 4);
    M_mem[0][0] = 32'h3F800000;
    z_if.c[0] = 32'h80000000;
    cur.c[0] = 32'h80000000;
    run_op("negzero");

    // n=0: two-cycle run, previous results cleared
    new_case(0, 0, 0, 2);
    run_op("n0");

    // Reset in the middle of RUN
    new_case(2, 1, 0, 14);
    M_mem[0][0] = 32'h3F800000; M_mem[1][1] = 32'h3F800000;
    z_if.c[0] = 32'h3F800000; z_if.c[1] = 32'h40000000;
    z_if.G[0][0] = 32'h3F800000; z_if.G[1][0] = 32'h40400000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst busy before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy",  32'(busy),     32'd0);
    check("midrst done",  32'(done),     32'd0);
    check("midrst addr",  32'(m_addr),   32'd0);
    check("midrst n",     32'(out_if.n), 32'd0);
    check("midrst c0",    out_if.c[0],   32'd0);
    rst    = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst no done", 32'(pulses), 32'd0);
    cur.c[0] = 32'h3F800000; cur.c[1] = 32'h40000000;
    cur.G[0][0] = 32'h3F800000; cur.G[1][0] = 32'h40400000;
    run_op("after rst");

    // start held high: one done per run, re-accept right after DONE
    new_case(1, 0, 0, 4);
    M_mem[0][0] = 32'h40000000;
    z_if.c[0] = 32'h3F800000;
    cur.c[0] = 32'h40000000;
    sb_q.push_back(cur);
    sb_q.push_back(cur);
    @(negedge clk); start = 1'b1;
    cnt = 0;
    while (cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (done) break;
    end
    check("held first latency", 32'(cnt), 32'd4);
    compare_out("held#1", sb_q.pop_front());
    @(negedge clk);
    check("held done width", 32'(done), 32'd0);
    cnt = 1;
    while (cnt < 200 && !done) begin
      @(negedge clk);
      cnt++;
    end
    check("held reaccept interval", 32'(cnt), 32'd5);
    start = 1'b0;
    compare_out("held#2", sb_q.pop_front());
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("held no extra run", 32'(pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
